// File: rtl/meteor_spawn_scheduler.sv
// Meteor spawn scheduler: paces meteor spawns from frame ticks, hands each
// spawn to a free slot round-robin over a valid/ready handshake, and ramps
// difficulty by shortening the spawn interval as spawns are accepted.
module meteor_spawn_scheduler #(
   parameter int unsigned NUM_SLOTS        = 4,
   parameter int unsigned INIT_INTERVAL    = 60,
   parameter int unsigned MIN_INTERVAL     = 15,
   parameter int unsigned STEP             = 5,
   parameter int unsigned SPAWNS_PER_LEVEL = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_tick,
   input  logic                 enable,
   input  logic [15:0]          rnd,
   input  logic [NUM_SLOTS-1:0] retire,
   output logic                 spawn_valid,
   input  logic                 spawn_ready,
   output logic [1:0]           spawn_slot,
   output logic [9:0]           spawn_x,
   output logic [9:0]           spawn_y,
   output logic [9:0]           spawn_size,
   output logic [NUM_SLOTS-1:0] active_mask,
   output logic [7:0]           interval,
   output logic [2:0]           level
);

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      PICK  = 2'd1,
      OFFER = 2'd2
   } state_t;

   localparam logic [7:0] INIT_V  = 8'(INIT_INTERVAL);
   localparam logic [8:0] MIN_V   = 9'(MIN_INTERVAL);
   localparam logic [8:0] STEP_V  = 9'(STEP);
   localparam logic [7:0] LVL_END = 8'(SPAWNS_PER_LEVEL - 1);
   localparam logic [1:0] LAST_RST = 2'(NUM_SLOTS - 1);

   state_t               state_q, state_d;
   logic [7:0]           timer_q, timer_d;
   logic [NUM_SLOTS-1:0] active_q, active_d;
   logic [1:0]           slot_q, slot_d;
   logic [1:0]           last_q, last_d;
   logic [9:0]           x_q, x_d;
   logic [9:0]           y_q, y_d;
   logic [9:0]           size_q, size_d;
   logic [7:0]           interval_q, interval_d;
   logic [2:0]           level_q, level_d;
   logic [7:0]           cnt_q, cnt_d;

   logic                 pick_found;
   logic [1:0]           pick_idx;
   int unsigned          cand;

   // Round-robin search: first free slot upward from last_granted+1, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_q;
      cand       = 0;
      for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
         cand = (32'(last_q) + i) % NUM_SLOTS;
         if (!pick_found && !active_q[cand[1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[1:0];
         end
      end
   end

   // Next-state logic for the spawn FSM, slot occupancy and difficulty.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      active_d   = active_q & ~retire;
      slot_d     = slot_q;
      last_d     = last_q;
      x_d        = x_q;
      y_d        = y_q;
      size_d     = size_q;
      interval_d = interval_q;
      level_d    = level_q;
      cnt_d      = cnt_q;

      case (state_q)
         WAIT: begin
            if (frame_tick && enable && (timer_q < interval_q))
               timer_d = timer_q + 8'd1;
            if ((timer_q >= interval_q) && !(&active_q))
               state_d = PICK;
         end
         PICK: begin
            slot_d  = pick_idx;
            x_d     = 10'd640 + {4'd0, rnd[15:10]};
            y_d     = {2'd0, rnd[9:2]};
            size_d  = 10'd20 + ({8'd0, rnd[1:0]} * 10'd10);
            state_d = OFFER;
         end
         OFFER: begin
            if (spawn_ready) begin
               // Grant wins over any retire on the same slot; that slot was
               // free, so a retire there is a no-op anyway.
               active_d[slot_q] = 1'b1;
               last_d  = slot_q;
               timer_d = '0;
               state_d = WAIT;
               if (cnt_q == LVL_END) begin
                  cnt_d = '0;
                  if (level_q != 3'd7)
                     level_d = level_q + 3'd1;
                  if ({1'b0, interval_q} >= (MIN_V + STEP_V))
                     interval_d = interval_q - STEP_V[7:0];
                  else
                     interval_d = MIN_V[7:0];
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = WAIT;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT;
         timer_q    <= '0;
         active_q   <= '0;
         slot_q     <= '0;
         last_q     <= LAST_RST;
         x_q        <= '0;
         y_q        <= '0;
         size_q     <= '0;
         interval_q <= INIT_V;
         level_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         active_q   <= active_d;
         slot_q     <= slot_d;
         last_q     <= last_d;
         x_q        <= x_d;
         y_q        <= y_d;
         size_q     <= size_d;
         interval_q <= interval_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
      end
   end

   assign spawn_valid = (state_q == OFFER);
   assign spawn_slot  = slot_q;
   assign spawn_x     = x_q;
   assign spawn_y     = y_q;
   assign spawn_size  = size_q;
   assign active_mask = active_q;
   assign interval    = interval_q;
   assign level       = level_q;

endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// Directed bench for meteor_spawn_scheduler with hand-computed expectations.
module tb_meteor_spawn_scheduler;

   logic        clk;
   logic        rst_n;
   logic        frame_tick;
   logic        enable;
   logic [15:0] rnd;
   logic [3:0]  retire;
   logic        spawn_valid;
   logic        spawn_ready;
   logic [1:0]  spawn_slot;
   logic [9:0]  spawn_x;
   logic [9:0]  spawn_y;
   logic [9:0]  spawn_size;
   logic [3:0]  active_mask;
   logic [7:0]  interval;
   logic [2:0]  level;

   int checks;
   int failures;
   int n_acc;
   int m_cnt;
   int m_lvl;
   int m_int;
   bit got;
   bit bad;

   meteor_spawn_scheduler #(
      .NUM_SLOTS(4),
      .INIT_INTERVAL(60),
      .MIN_INTERVAL(15),
      .STEP(5),
      .SPAWNS_PER_LEVEL(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_tick(frame_tick),
      .enable(enable),
      .rnd(rnd),
      .retire(retire),
      .spawn_valid(spawn_valid),
      .spawn_ready(spawn_ready),
      .spawn_slot(spawn_slot),
      .spawn_x(spawn_x),
      .spawn_y(spawn_y),
      .spawn_size(spawn_size),
      .active_mask(active_mask),
      .interval(interval),
      .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold frame_tick until the DUT offers a spawn (bounded); leaves DUT in OFFER.
   task automatic wait_offer(input logic [15:0] r, output bit ok);
      rnd = r;
      frame_tick = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (spawn_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      frame_tick = 1'b0;
      check("offer_timeout", {31'd0, ok}, 32'd1);
   endtask

   // One accepted spawn after clearing all slots, with level/interval model.
   task automatic spawn_one();
      retire = 4'hF;
      step();
      retire = 4'h0;
      wait_offer(16'($urandom), got);
      step();
      n_acc++;
      m_cnt++;
      if (m_cnt == 8) begin
         m_cnt = 0;
         if (m_lvl < 7) m_lvl++;
         m_int = (m_int - 5 < 15) ? 15 : m_int - 5;
      end
      check("lvl_model", {29'd0, level}, 32'(m_lvl));
      check("int_model", {24'd0, interval}, 32'(m_int));
   endtask

   initial begin
      checks = 0; failures = 0; n_acc = 0;
      rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b1; rnd = 16'hFFFF;
      retire = 4'h0; spawn_ready = 1'b1;
      step();
      step();
      check("rst_valid", {31'd0, spawn_valid}, 32'd0);
      check("rst_mask", {28'd0, active_mask}, 32'd0);
      check("rst_slot", {30'd0, spawn_slot}, 32'd0);
      check("rst_x", {22'd0, spawn_x}, 32'd0);
      check("rst_size", {22'd0, spawn_size}, 32'd0);
      check("rst_interval", {24'd0, interval}, 32'd60);
      check("rst_level", {29'd0, level}, 32'd0);
      rst_n = 1'b1;

      // 60 frame ticks -> PICK -> OFFER on slot 0 with rnd=FFFF payload
      frame_tick = 1'b1;
      repeat (59) step();
      check("t59_valid", {31'd0, spawn_valid}, 32'd0);
      step();
      frame_tick = 1'b0;
      check("t60_valid", {31'd0, spawn_valid}, 32'd0);
      step();
      check("pick_valid", {31'd0, spawn_valid}, 32'd0);
      step();
      check("offer_valid", {31'd0, spawn_valid}, 32'd1);
      check("s0_slot", {30'd0, spawn_slot}, 32'd0);
      check("ff_x", {22'd0, spawn_x}, 32'd703);
      check("ff_y", {22'd0, spawn_y}, 32'd255);
      check("ff_size", {22'd0, spawn_size}, 32'd50);
      step();
      check("acc_valid", {31'd0, spawn_valid}, 32'd0);
      check("acc_mask", {28'd0, active_mask}, 32'd1);
      n_acc = 1;

      // rnd=0 -> slot 1, 640/0/20
      wait_offer(16'h0000, got);
      check("s1_slot", {30'd0, spawn_slot}, 32'd1);
      check("z_x", {22'd0, spawn_x}, 32'd640);
      check("z_y", {22'd0, spawn_y}, 32'd0);
      check("z_size", {22'd0, spawn_size}, 32'd20);
      step();
      check("s1_mask", {28'd0, active_mask}, 32'h3);

      // rnd=A5C6 -> x=681 y=113 size=40 on slot 2
      wait_offer(16'hA5C6, got);
      check("s2_slot", {30'd0, spawn_slot}, 32'd2);
      check("a5_x", {22'd0, spawn_x}, 32'd681);
      check("a5_y", {22'd0, spawn_y}, 32'd113);
      check("a5_size", {22'd0, spawn_size}, 32'd40);
      step();

      // rnd=0001 -> size 30 on slot 3
      wait_offer(16'h0001, got);
      check("s3_slot", {30'd0, spawn_slot}, 32'd3);
      check("one_size", {22'd0, spawn_size}, 32'd30);
      step();
      check("full_mask", {28'd0, active_mask}, 32'hF);
      n_acc = 4;

      // all slots busy: no spawn however long the timer runs
      frame_tick = 1'b1;
      bad = 1'b0;
      repeat (80) begin
         step();
         if (spawn_valid) bad = 1'b1;
      end
      frame_tick = 1'b0;
      check("full_no_spawn", {31'd0, bad}, 32'd0);
      retire = 4'b0100;
      step();
      retire = 4'h0;
      check("ret2_mask", {28'd0, active_mask}, 32'hB);
      check("ret2_c1", {31'd0, spawn_valid}, 32'd0);
      step();
      check("ret2_c2", {31'd0, spawn_valid}, 32'd0);
      step();
      check("ret2_c3", {31'd0, spawn_valid}, 32'd1);
      check("ret2_slot", {30'd0, spawn_slot}, 32'd2);
      step();
      check("ret2_mask2", {28'd0, active_mask}, 32'hF);
      n_acc = 5;

      // stalled OFFER with enable dropped; payload from rnd=1234 -> 644/141/20
      spawn_ready = 1'b0;
      retire = 4'b0001;
      step();
      retire = 4'h0;
      wait_offer(16'h1234, got);
      enable = 1'b0;
      rnd = 16'hFFFF;
      bad = 1'b0;
      repeat (10) begin
         step();
         if (spawn_valid !== 1'b1 || spawn_slot !== 2'd0 || spawn_x !== 10'd644 ||
             spawn_y !== 10'd141 || spawn_size !== 10'd20) bad = 1'b1;
      end
      check("stall_stable", {31'd0, bad}, 32'd0);
      // handshake on slot 0 while slot 1 retires in the same cycle
      spawn_ready = 1'b1;
      retire = 4'b0010;
      step();
      retire = 4'h0;
      enable = 1'b1;
      check("stall_done", {31'd0, spawn_valid}, 32'd0);
      check("same_cyc_mask", {28'd0, active_mask}, 32'hD);
      check("hold_x", {22'd0, spawn_x}, 32'd644);
      check("hold_slot", {30'd0, spawn_slot}, 32'd0);
      n_acc = 6;

      // difficulty ramp
      m_cnt = 6; m_lvl = 0; m_int = 60;
      spawn_one();
      spawn_one();
      check("lvl1_level", {29'd0, level}, 32'd1);
      check("lvl1_interval", {24'd0, interval}, 32'd55);
      while (n_acc < 72) spawn_one();
      check("lvl9_level", {29'd0, level}, 32'd7);
      check("lvl9_interval", {24'd0, interval}, 32'd15);
      while (n_acc < 80) spawn_one();
      check("floor_interval", {24'd0, interval}, 32'd15);

      // reset in the middle of OFFER
      spawn_ready = 1'b0;
      retire = 4'hF;
      step();
      retire = 4'h0;
      wait_offer(16'h5555, got);
      check("pre_rst_valid", {31'd0, spawn_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, spawn_valid}, 32'd0);
      check("mid_rst_mask", {28'd0, active_mask}, 32'd0);
      check("mid_rst_interval", {24'd0, interval}, 32'd60);
      check("mid_rst_level", {29'd0, level}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_mask", {28'd0, active_mask}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
